// File: rtl/uart_apb_pkg.sv
// Shared definitions for the CoreUARTapb initiator: register map, STATUS/err bit
// positions, FSM encoding and the APB request bundle.
package uart_apb_pkg;

  localparam logic [4:0] REG_TXDATA = 5'h00;
  localparam logic [4:0] REG_RXDATA = 5'h04;
  localparam logic [4:0] REG_CTRL1  = 5'h08;
  localparam logic [4:0] REG_CTRL2  = 5'h0C;
  localparam logic [4:0] REG_STATUS = 5'h10;
  localparam logic [4:0] REG_CTRL3  = 5'h14;

  localparam int ST_TXRDY    = 0;
  localparam int ST_RXRDY    = 1;
  localparam int ST_PARITY   = 2;
  localparam int ST_OVERFLOW = 3;
  localparam int ST_FRAMING  = 4;

  localparam int ERR_PARITY   = 0;
  localparam int ERR_OVERFLOW = 1;
  localparam int ERR_FRAMING  = 2;
  localparam int ERR_SLVERR   = 3;

  localparam logic [2:0] S_INIT1 = 3'd0;
  localparam logic [2:0] S_INIT2 = 3'd1;
  localparam logic [2:0] S_INIT3 = 3'd2;
  localparam logic [2:0] S_POLL  = 3'd3;
  localparam logic [2:0] S_RXRD  = 3'd4;
  localparam logic [2:0] S_TXWR  = 3'd5;

  typedef struct packed {
    logic [4:0] addr;
    logic       write;
    logic [7:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/uart_apb_initiator_if.sv
// APB3 bus between the UART initiator (master) and a CoreUARTapb target (slave).
interface uart_apb_initiator_if;
  logic [4:0] PADDR;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/uart_byte_fifo.sv
// First-word fall-through byte FIFO with synchronous reset; pop on empty is ignored,
// push on full is accepted only when a pop frees the head slot in the same cycle.
module uart_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_apb_initiator.sv
// APB3 master for CoreUARTapb: programs baud/config once, then polls STATUS and moves
// bytes between the UART and a pair of valid/ready byte-stream FIFOs.
module uart_apb_initiator
  import uart_apb_pkg::*;
#(
  parameter logic [12:0] BAUD_VALUE = 13'd1,
  parameter logic [2:0]  BAUD_FRCTN = 3'd0,
  parameter bit          FRCTN_EN   = 1'b1,
  parameter bit          BIT8       = 1'b1,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          ODD_N_EVEN = 1'b0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic       PCLK,
  input  logic       PRESET,
  uart_apb_initiator_if.master apb,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [3:0] err_flags,
  input  logic       err_clr,
  output logic       init_done
);
  logic [2:0] state, nxt_state, issue_state;
  logic       psel, penable, done, issue;
  apb_req_t   req, nxt_req;
  logic       rx_full, rx_empty, rx_push;
  logic       tx_full, tx_empty, tx_pop;
  logic [7:0] tx_head;
  logic [3:0] err_set;

  assign done        = psel & penable & apb.PREADY;
  // A new SETUP is loaded either straight out of reset or on the completing edge.
  assign issue       = ~psel | done;
  assign issue_state = psel ? nxt_state : state;
  assign tx_pop      = issue & (issue_state == S_TXWR);
  assign rx_push     = done & (state == S_RXRD);

  assign rx_valid = ~rx_empty;
  assign tx_ready = init_done & ~tx_full;

  assign apb.PSEL    = psel;
  assign apb.PENABLE = penable;
  assign apb.PADDR   = req.addr;
  assign apb.PWRITE  = req.write;
  assign apb.PWDATA  = req.wdata;

  uart_byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) rx_fifo (
    .clk       (PCLK),
    .rst       (PRESET),
    .push      (rx_push),
    .push_data (apb.PRDATA),
    .pop       (rx_valid & rx_ready),
    .head      (rx_data),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  uart_byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) tx_fifo (
    .clk       (PCLK),
    .rst       (PRESET),
    .push      (tx_valid & tx_ready),
    .push_data (tx_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  // RX beats TX so the UART's single receive holding register drains first.
  always_comb begin
    nxt_state = S_POLL;
    case (state)
      S_INIT1: nxt_state = S_INIT2;
      S_INIT2: nxt_state = FRCTN_EN ? S_INIT3 : S_POLL;
      S_INIT3: nxt_state = S_POLL;
      S_POLL: begin
        if (apb.PRDATA[ST_RXRDY] && !rx_full)      nxt_state = S_RXRD;
        else if (apb.PRDATA[ST_TXRDY] && !tx_empty) nxt_state = S_TXWR;
        else                                        nxt_state = S_POLL;
      end
      default: nxt_state = S_POLL;
    endcase
  end

  always_comb begin
    nxt_req.addr  = REG_STATUS;
    nxt_req.write = 1'b0;
    nxt_req.wdata = req.wdata;
    case (issue_state)
      S_INIT1: begin
        nxt_req.addr  = REG_CTRL1;
        nxt_req.write = 1'b1;
        nxt_req.wdata = BAUD_VALUE[7:0];
      end
      S_INIT2: begin
        nxt_req.addr  = REG_CTRL2;
        nxt_req.write = 1'b1;
        nxt_req.wdata = {BAUD_VALUE[12:8], ODD_N_EVEN, PARITY_EN, BIT8};
      end
      S_INIT3: begin
        nxt_req.addr  = REG_CTRL3;
        nxt_req.write = 1'b1;
        nxt_req.wdata = {5'b0, BAUD_FRCTN};
      end
      S_RXRD: nxt_req.addr = REG_RXDATA;
      S_TXWR: begin
        nxt_req.addr  = REG_TXDATA;
        nxt_req.write = 1'b1;
        nxt_req.wdata = tx_head;
      end
      default: ;
    endcase
  end

  always_comb begin
    err_set = '0;
    if (done) begin
      err_set[ERR_SLVERR] = apb.PSLVERR;
      if (state == S_POLL) begin
        err_set[ERR_PARITY]   = apb.PRDATA[ST_PARITY];
        err_set[ERR_OVERFLOW] = apb.PRDATA[ST_OVERFLOW];
        err_set[ERR_FRAMING]  = apb.PRDATA[ST_FRAMING];
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= S_INIT1;
      psel      <= 1'b0;
      penable   <= 1'b0;
      req       <= '0;
      init_done <= 1'b0;
      err_flags <= '0;
    end else begin
      if (issue) begin
        psel    <= 1'b1;
        penable <= 1'b0;
        req     <= nxt_req;
        state   <= issue_state;
      end else if (!penable) begin
        penable <= 1'b1;
      end
      if (done && (state == S_INIT3 || (state == S_INIT2 && !FRCTN_EN)))
        init_done <= 1'b1;
      // A new error in the same cycle as err_clr survives the clear.
      err_flags <= (err_flags & ~{4{err_clr}}) | err_set;
    end
  end
endmodule

// File: tb/tb_uart_apb_initiator.sv
// Scoreboarded bench: a CoreUARTapb-style responder with wait/error injection feeds the
// initiator; expected APB transfers and RX bytes are queued and checked by a monitor.
module tb_uart_apb_initiator;
  logic       PCLK = 1'b0;
  logic       PRESET;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [3:0] err_flags;
  logic       err_clr, init_done;

  uart_apb_initiator_if apb();

  uart_apb_initiator #(
    .BAUD_VALUE(13'h1A5), .BAUD_FRCTN(3'd3), .FRCTN_EN(1'b1),
    .BIT8(1'b1), .PARITY_EN(1'b1), .ODD_N_EVEN(1'b1), .FIFO_DEPTH(4)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .apb(apb),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .err_flags(err_flags), .err_clr(err_clr), .init_done(init_done)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] addr;
    logic       write;
    logic [7:0] wdata;
    bit         strict;
  } exp_t;
  exp_t       exp_q[$];
  logic [7:0] rx_exp[$];

  // responder state
  logic [7:0] rxmem [16];
  logic [7:0] rx_wr = 8'd0, rx_rd = 8'd0;
  logic       txrdy = 1'b0;
  logic       pready = 1'b1;
  logic       slv_flag = 1'b0, err_shot = 1'b0;
  logic       stall_req = 1'b0, stall_slv = 1'b0, stall_err = 1'b0;
  logic [4:0] stall_addr = 5'h10;
  int         stall_left = 0;
  logic [7:0] status, prd;
  logic       pend_done = 1'b0;
  logic [4:0] pend_addr = 5'h0;

  always_comb begin
    status = {3'b000, err_shot ? 3'b111 : 3'b000, (rx_wr != rx_rd), txrdy};
    case (apb.PADDR)
      5'h10:   prd = status;
      5'h04:   prd = rxmem[rx_rd[3:0]];
      default: prd = 8'h00;
    endcase
  end
  assign apb.PRDATA  = prd;
  assign apb.PREADY  = pready;
  assign apb.PSLVERR = slv_flag & apb.PSEL & apb.PENABLE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_x(input logic [4:0] a, input logic w, input logic [7:0] d, input bit s);
    exp_t e;
    e.addr = a; e.write = w; e.wdata = d; e.strict = s;
    exp_q.push_back(e);
  endtask

  task automatic check_xfer(input logic [4:0] a, input logic w, input logic [7:0] d);
    exp_t e;
    if (exp_q.size() == 0 || (!exp_q[0].strict && a == 5'h10)) begin
      if (a != 5'h10) begin
        checks++; errors++;
        $display("FAIL xfer_unexpected: got addr=%h write=%b data=%h, expected only STATUS polls", a, w, d);
      end
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (a !== e.addr || w !== e.write || (e.write && d !== e.wdata)) begin
      errors++;
      $display("FAIL xfer: got addr=%h write=%b data=%h, expected addr=%h write=%b data=%h",
               a, w, d, e.addr, e.write, e.wdata);
    end
  endtask

  task automatic check_rx(input logic [7:0] d);
    logic [7:0] e;
    checks++;
    if (rx_exp.size() == 0) begin
      errors++;
      $display("FAIL rx_unexpected: got %h, expected no byte", d);
      return;
    end
    e = rx_exp.pop_front();
    if (d !== e) begin
      errors++;
      $display("FAIL rx_data: got %h, expected %h", d, e);
    end
  endtask

  // monitor + responder: sample at negedge, update responder state just after posedge
  initial begin
    forever begin
      @(negedge PCLK);
      pend_done = 1'b0;
      if (!PRESET && apb.PSEL && apb.PENABLE && apb.PREADY) begin
        check_xfer(apb.PADDR, apb.PWRITE, apb.PWDATA);
        pend_done = 1'b1;
        pend_addr = apb.PADDR;
      end
      if (!PRESET && rx_valid && rx_ready) check_rx(rx_data);
      @(posedge PCLK);
      #1;
      if (pend_done) begin
        if (pend_addr == 5'h04) rx_rd = rx_rd + 8'd1;
        slv_flag = 1'b0;
        err_shot = 1'b0;
      end
      if (apb.PSEL && apb.PENABLE && stall_left > 0) begin
        pready = 1'b0;
        stall_left--;
      end else pready = 1'b1;
      if (apb.PSEL && !apb.PENABLE && stall_req && apb.PADDR == stall_addr) begin
        stall_left = 3;
        stall_req  = 1'b0;
        slv_flag   = stall_slv;
        err_shot   = stall_err;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic load_rx(input logic [7:0] b);
    rxmem[rx_wr[3:0]] = b;
    rx_wr = rx_wr + 8'd1;
  endtask

  task automatic wait_sb(input string name, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin @(negedge PCLK); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d transfers outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_rx(input string name, input int max);
    int n = 0;
    while (rx_exp.size() != 0 && n < max) begin @(negedge PCLK); n++; end
    checks++;
    if (rx_exp.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d rx bytes undelivered, expected 0", name, rx_exp.size());
      rx_exp.delete();
    end
  endtask

  task automatic send_tx(input logic [7:0] b);
    int n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge PCLK);
    while (!tx_ready && n < 50) begin @(negedge PCLK); n++; end
    chk("tx_accept", 32'(tx_ready), 32'd1);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_stall(input string name, input logic [4:0] a);
    int n = 0;
    @(negedge PCLK);
    while (!(apb.PSEL && apb.PENABLE && !apb.PREADY && apb.PADDR == a) && n < 60) begin
      @(negedge PCLK); n++;
    end
    chk(name, 32'(apb.PSEL && apb.PENABLE && !apb.PREADY), 32'd1);
  endtask

  task automatic expect_init;
    expect_x(5'h08, 1'b1, 8'hA5, 1'b1);
    expect_x(5'h0C, 1'b1, 8'h0F, 1'b1);
    expect_x(5'h14, 1'b1, 8'h03, 1'b1);
    expect_x(5'h10, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    PRESET = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("rst_psel",    32'(apb.PSEL),    32'd0);
    chk("rst_penable", 32'(apb.PENABLE), 32'd0);
    chk("rst_pwrite",  32'(apb.PWRITE),  32'd0);
    chk("rst_paddr",   32'(apb.PADDR),   32'd0);
    chk("rst_pwdata",  32'(apb.PWDATA),  32'd0);
    chk("rst_tx_ready", 32'(tx_ready),   32'd0);
    chk("rst_rx_valid", 32'(rx_valid),   32'd0);
    chk("rst_err",     32'(err_flags),   32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);

    // init writes CTRL1, CTRL2, CTRL3, then first poll
    expect_init();
    tick(); PRESET = 1'b0;
    wait_sb("init_seq", 60);
    chk("init_done", 32'(init_done), 32'd1);
    chk("init_tx_ready", 32'(tx_ready), 32'd1);

    // single RX byte, then back to polling
    rx_ready = 1'b1;
    expect_x(5'h04, 1'b0, 8'h00, 1'b0);
    expect_x(5'h10, 1'b0, 8'h00, 1'b1);
    rx_exp.push_back(8'h5C);
    tick(); load_rx(8'h5C);
    wait_sb("rx_single", 60);
    wait_rx("rx_single_deliver", 30);

    // two TX bytes with a poll between
    expect_x(5'h00, 1'b1, 8'h11, 1'b0);
    expect_x(5'h10, 1'b0, 8'h00, 1'b1);
    expect_x(5'h00, 1'b1, 8'h22, 1'b1);
    tick(); txrdy = 1'b1;
    send_tx(8'h11);
    send_tx(8'h22);
    wait_sb("tx_pair", 60);
    chk("tx_ready_hold", 32'(tx_ready), 32'd1);

    // RX and TX both ready: RXDATA read first
    tick(); txrdy = 1'b0;
    send_tx(8'h33);
    repeat (4) tick();
    expect_x(5'h04, 1'b0, 8'h00, 1'b0);
    expect_x(5'h10, 1'b0, 8'h00, 1'b1);
    expect_x(5'h00, 1'b1, 8'h33, 1'b1);
    rx_exp.push_back(8'hA7);
    load_rx(8'hA7); txrdy = 1'b1;
    wait_sb("rx_before_tx", 60);
    wait_rx("rx_before_tx_deliver", 30);

    // RX FIFO full: no RXDATA reads until space appears
    tick(); rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) expect_x(5'h04, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      load_rx(8'hC0 + 8'(i));
      rx_exp.push_back(8'hC0 + 8'(i));
    end
    wait_sb("rx_fill", 80);
    repeat (30) @(negedge PCLK);
    chk("rx_full_valid", 32'(rx_valid), 32'd1);
    chk("rx_full_head",  32'(rx_data),  32'hC0);
    expect_x(5'h04, 1'b0, 8'h00, 1'b0);
    tick(); rx_ready = 1'b1;
    tick(); rx_ready = 1'b0;
    wait_sb("rx_one_more", 40);
    repeat (30) @(negedge PCLK);
    chk("rx_head_after_pop", 32'(rx_data), 32'hC1);
    expect_x(5'h04, 1'b0, 8'h00, 1'b0);
    tick(); rx_ready = 1'b1;
    wait_sb("rx_drain", 60);
    wait_rx("rx_drain_deliver", 60);

    // stalled poll with PSLVERR and all status error bits
    tick(); txrdy = 1'b0;
    stall_addr = 5'h10; stall_slv = 1'b1; stall_err = 1'b1; stall_req = 1'b1;
    wait_stall("stall_seen", 5'h10);
    for (int i = 0; i < 3; i++) begin
      chk("stall_hold", {apb.PSEL, apb.PENABLE, 25'(apb.PADDR)}, {1'b1, 1'b1, 25'h10});
      @(negedge PCLK);
    end
    repeat (4) @(negedge PCLK);
    chk("err_sticky", 32'(err_flags), 32'hF);
    tick(); err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    @(negedge PCLK);
    chk("err_cleared", 32'(err_flags), 32'h0);

    // reset during a stalled TXDATA write
    rx_ready = 1'b0;
    send_tx(8'h44);
    send_tx(8'h55);
    expect_x(5'h04, 1'b0, 8'h00, 1'b0);
    tick(); load_rx(8'h66);
    wait_sb("rx_hold", 60);
    @(negedge PCLK);
    chk("rx_hold_valid", 32'(rx_valid), 32'd1);
    tick(); stall_addr = 5'h00; stall_slv = 1'b0; stall_err = 1'b0; stall_req = 1'b1; txrdy = 1'b1;
    wait_stall("txwr_stall", 5'h00);
    PRESET = 1'b1;
    exp_q.delete(); rx_exp.delete();
    stall_left = 0; stall_req = 1'b0; rx_rd = rx_wr;
    @(negedge PCLK);
    chk("mid_rst_psel",    32'(apb.PSEL),    32'd0);
    chk("mid_rst_penable", 32'(apb.PENABLE), 32'd0);
    chk("mid_rst_rx_valid", 32'(rx_valid),   32'd0);
    chk("mid_rst_tx_ready", 32'(tx_ready),   32'd0);
    chk("mid_rst_init_done", 32'(init_done), 32'd0);
    expect_init();
    tick(); PRESET = 1'b0;
    wait_sb("reinit_seq", 60);
    repeat (30) @(negedge PCLK);
    chk("reinit_rx_valid", 32'(rx_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
